// File: rtl/signed_bin2bcd.sv
// Sequential two's-complement to sign-magnitude BCD converter.
// Uses one double-dabble step per cycle: IDLE -> CONVERT (WIDTH cycles) -> DONE.
module signed_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic               neg_q,     neg_d;
    logic [WIDTH-1:0]   mag_q,     mag_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               sign_q,    sign_d;
    logic [BCD_W-1:0]   bcd_q,     bcd_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   step_scratch;
    logic [WIDTH-1:0]   step_mag;

    // One double-dabble step: bias digits >= 5 so the shift carries into the next digit.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        step_scratch = {adj[BCD_W-2:0], mag_q[WIDTH-1]};
        step_mag     = {mag_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no latch is inferred.
        state_d   = state_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d     = din[WIDTH-1];
                    // Unsigned WIDTH-bit magnitude: the most negative input maps to 2^(WIDTH-1).
                    mag_d     = din[WIDTH-1] ? (~din + WIDTH'(1)) : din;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = step_scratch;
                mag_d     = step_mag;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Publish the final step directly so results are visible in the DONE cycle.
                    bcd_d   = step_scratch;
                    sign_d  = neg_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (state_q == CONVERT);
    assign done = (state_q == DONE);
    assign sign = sign_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_signed_bin2bcd.sv
// Scoreboard bench for signed_bin2bcd: stimulus pushes expected results, a negedge monitor checks them.
module tb_signed_bin2bcd;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  din;
    logic              busy;
    logic              done;
    logic              sign;
    logic [4*DIGITS-1:0] bcd;

    typedef struct {
        int                  due;
        logic                sign;
        logic [4*DIGITS-1:0] bcd;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   busy_lo = -1;
    int   busy_hi = -2;
    bit   mon_en = 1'b0;
    logic                model_sign = 1'b0;
    logic [4*DIGITS-1:0] model_bcd = '0;

    signed_bin2bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .sign  (sign),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the signed value.
    task automatic push_expected(input logic [WIDTH-1:0] v, input int t);
        int   s;
        int   m;
        exp_t e;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        e.due  = t + WIDTH + 1;
        e.sign = (s < 0);
        e.bcd  = '0;
        for (int d = 0; d < DIGITS; d++) begin
            e.bcd[4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        exp_q.push_back(e);
        busy_lo = t + 1;
        busy_hi = t + WIDTH;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_done;
            exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            check("done", 32'(done), 32'(exp_done));
            if (done && exp_q.size() > 0) begin
                exp_t e;
                int   bad;
                e = exp_q.pop_front();
                check("latency", 32'(cyc), 32'(e.due));
                check("sign", 32'(sign), 32'(e.sign));
                check("bcd", 32'(bcd), 32'(e.bcd));
                bad = 0;
                for (int d = 0; d < DIGITS; d++) if (bcd[4*d +: 4] > 4'd9) bad++;
                check("bcd_digits_valid", 32'(bad), 32'd0);
                model_sign = e.sign;
                model_bcd  = e.bcd;
            end else if (!done) begin
                check("hold_sign", 32'(sign), 32'(model_sign));
                check("hold_bcd", 32'(bcd), 32'(model_bcd));
            end
        end
    end

    // Start pulse in cycle T, din scrambled afterwards; returns at the posedge starting T+17.
    task automatic issue(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        start = 1'b1;
        din   = v;
        push_expected(v, cyc);
        @(posedge clk); #1;
        start = 1'b0;
        din   = WIDTH'($urandom);
        repeat (WIDTH) @(posedge clk);
    endtask

    initial begin
        int t;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        mon_en = 1'b1;

        issue(16'h0000);
        issue(16'hFFFF);
        issue(16'h7FFF);
        issue(16'h8000);
        issue(16'hCFC7);
        issue(16'h3039);

        // Start re-asserted mid-conversion must be ignored.
        @(posedge clk); #1;
        t = cyc;
        start = 1'b1;
        din   = 16'h0064;
        push_expected(16'h0064, t);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 16'hFF9C;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);

        // Reset in the middle of a conversion: no done, outputs cleared.
        @(posedge clk); #1;
        t = cyc;
        start = 1'b1;
        din   = 16'h1234;
        push_expected(16'h1234, t);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        busy_hi = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_sign = 1'b0;
        model_bcd  = '0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sign", 32'(sign), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        issue(16'h1234);

        // start held high: a new conversion on every IDLE cycle, din taken from that cycle.
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < WIDTH + 2; c++) begin
                if (c == 0) begin
                    din = WIDTH'($urandom);
                    push_expected(din, cyc);
                end else begin
                    din = WIDTH'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;

        for (int n = 0; n < 1000; n++) begin
            issue(WIDTH'($urandom));
        end

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
